pipelined_adder: RTL and testbench

//  Parametrised, pipelined add/subtract unit for the RISC datapath ALU; the

---
 rtl/pipelined_adder_pkg.sv | 20 ++
 rtl/adder_chunk.sv | 28 ++
 rtl/pipelined_adder.sv | 139 +++++++++++++
 tb/tb_pipelined_adder.sv | 338 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipelined_adder_pkg.sv
// Shared definitions for the pipelined add/subtract unit.
// Operation encodings and the flag layout also used by the ALU flag register.
package pipelined_adder_pkg;

    localparam logic ALU_ADD = 1'b0;
    localparam logic ALU_SUB = 1'b1;

    localparam int FLAG_C = 0;
    localparam int FLAG_V = 1;
    localparam int FLAG_Z = 2;
    localparam int FLAG_N = 3;

    typedef struct packed {
        logic n;
        logic z;
        logic v;
        logic c;
    } flags_t;

endpackage

// File: rtl/adder_chunk.sv
// Combinational ripple-carry slice used by each pipeline stage.
// Also exposes the carry into the slice MSB for signed-overflow detection.
module adder_chunk #(
    parameter int CHUNK = 8
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    input  logic             ci,
    output logic [CHUNK-1:0] s,
    output logic             co,
    output logic             c_msb
);

    logic [CHUNK:0] c;

    always_comb begin
        c = '0;
        c[0] = ci;
        for (int i = 0; i < CHUNK; i++) begin
            c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
        end
    end

    assign s     = a ^ b ^ c[CHUNK-1:0];
    assign co    = c[CHUNK];
    assign c_msb = c[CHUNK-1];

endmodule

// File: rtl/pipelined_adder.sv
// STAGES-deep add/subtract pipeline with valid/ready handshake and global stall.
// Each stage adds one CHUNK slice; unconsumed operand bits travel alongside.
module pipelined_adder
    import pipelined_adder_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int STAGES = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Cin,
    input  logic             Sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] Out,
    output logic             Cout,
    output logic             Ovf,
    output logic             Zero,
    output logic             Neg
);

    localparam int CHUNK = WIDTH / STAGES;
    localparam int LAST  = STAGES - 1;
    localparam int NREG  = (STAGES > 1) ? STAGES - 1 : 1;

    logic             adv;
    logic             vi [STAGES];
    logic             ci [STAGES];
    logic             co [STAGES];
    logic             cm [STAGES];
    logic [WIDTH-1:0] ai [STAGES];
    logic [WIDTH-1:0] bi [STAGES];
    logic [WIDTH-1:0] ri [STAGES];
    logic [WIDTH-1:0] rn [STAGES];
    logic [CHUNK-1:0] s  [STAGES];

    logic             v_q [NREG];
    logic             c_q [NREG];
    logic [WIDTH-1:0] a_q [NREG];
    logic [WIDTH-1:0] b_q [NREG];
    logic [WIDTH-1:0] r_q [NREG];

    logic             ov_q;
    logic [WIDTH-1:0] out_q;
    flags_t           fl_q;
    flags_t           fl_d;

    // Operand bits already consumed by stage k and below are dropped.
    function automatic logic [WIDTH-1:0] hi_mask(input int k);
        return ~((WIDTH'(1) << ((k + 1) * CHUNK)) - WIDTH'(1));
    endfunction

    assign adv = !ov_q || out_ready;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        if (k == 0) begin : g_in
            assign vi[k] = in_valid;
            assign ai[k] = A;
            assign bi[k] = (Sub == ALU_SUB) ? ~B : B;
            assign ci[k] = Cin;
            assign ri[k] = '0;
        end else begin : g_pipe
            assign vi[k] = v_q[k-1];
            assign ai[k] = a_q[k-1];
            assign bi[k] = b_q[k-1];
            assign ci[k] = c_q[k-1];
            assign ri[k] = r_q[k-1];
        end

        adder_chunk #(
            .CHUNK(CHUNK)
        ) u_chunk (
            .a    (ai[k][k*CHUNK +: CHUNK]),
            .b    (bi[k][k*CHUNK +: CHUNK]),
            .ci   (ci[k]),
            .s    (s[k]),
            .co   (co[k]),
            .c_msb(cm[k])
        );

        assign rn[k] = ri[k] | (WIDTH'(s[k]) << (k * CHUNK));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < NREG; k++) begin
                v_q[k] <= 1'b0;
                c_q[k] <= 1'b0;
                a_q[k] <= '0;
                b_q[k] <= '0;
                r_q[k] <= '0;
            end
        end else if (adv) begin
            for (int k = 0; k < STAGES - 1; k++) begin
                v_q[k] <= vi[k];
                c_q[k] <= co[k];
                a_q[k] <= ai[k] & hi_mask(k);
                b_q[k] <= bi[k] & hi_mask(k);
                r_q[k] <= rn[k];
            end
        end
    end

    always_comb begin
        fl_d = '0;
        if (vi[LAST]) begin
            fl_d.c = co[LAST];
            fl_d.v = co[LAST] ^ cm[LAST];
            fl_d.z = (rn[LAST] == '0);
            fl_d.n = rn[LAST][WIDTH-1];
        end
    end

    // Idle output slots are zeroed so Out/flags read 0 while out_valid=0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ov_q  <= 1'b0;
            out_q <= '0;
            fl_q  <= '0;
        end else if (adv) begin
            ov_q  <= vi[LAST];
            out_q <= vi[LAST] ? rn[LAST] : '0;
            fl_q  <= fl_d;
        end
    end

    assign in_ready  = adv;
    assign out_valid = ov_q;
    assign Out       = out_q;
    assign Cout      = fl_q[FLAG_C];
    assign Ovf       = fl_q[FLAG_V];
    assign Zero      = fl_q[FLAG_Z];
    assign Neg       = fl_q[FLAG_N];

endmodule

// File: tb/tb_pipelined_adder.sv
// Scoreboard bench for pipelined_adder: directed 32x4 vectors, backpressure,
// async reset, and random sweeps on (8,1), (16,2), (64,8).
module tb_pipelined_adder;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_ready, out_valid, out_ready;
    logic [31:0] A, B, Out;
    logic        Cin, Sub, Cout, Ovf, Zero, Neg;

    int n_pass = 0;
    int n_tot  = 0;

    logic [67:0] q_m [$];
    int          streak = 0;
    int          max_streak = 0;
    bit          prev_pop = 0;
    bit          sw_go = 0;
    bit          sw_done [3];

    always #5 clk = ~clk;

    pipelined_adder #(
        .WIDTH (32),
        .STAGES(4)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .A        (A),
        .B        (B),
        .Cin      (Cin),
        .Sub      (Sub),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .Out      (Out),
        .Cout     (Cout),
        .Ovf      (Ovf),
        .Zero     (Zero),
        .Neg      (Neg)
    );

    task automatic chk(input string nm, input logic [67:0] got, input logic [67:0] exp);
        n_tot++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", nm, got, exp);
    endtask

    // Reference: {Cout, Ovf, Zero, Neg, result} for a w-bit add.
    function automatic logic [67:0] ref_add(input logic [63:0] x, input logic [63:0] y,
                                            input logic c, input logic s, input int w);
        logic [63:0] m, yy, r;
        logic [64:0] t;
        logic        v;
        m  = (w == 64) ? '1 : ((64'd1 << w) - 64'd1);
        yy = (s ? ~y : y) & m;
        t  = {1'b0, x & m} + {1'b0, yy} + {64'd0, c};
        r  = t[63:0] & m;
        v  = (x[w-1] == yy[w-1]) && (r[w-1] != x[w-1]);
        return {t[w], v, (r == 64'd0), r[w-1], r};
    endfunction

    function automatic logic [67:0] mk(input logic c, input logic v, input logic z,
                                       input logic n, input logic [63:0] r);
        return {c, v, z, n, r};
    endfunction

    task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic c,
                         input logic s, input logic [67:0] e);
        bit acc;
        acc = 0;
        A = a; B = b; Cin = c; Sub = s; in_valid = 1'b1;
        for (int t = 0; t < 50 && !acc; t++) begin
            @(negedge clk);
            if (in_ready) begin
                @(posedge clk);
                q_m.push_back(e);
                acc = 1;
            end else begin
                @(posedge clk);
            end
        end
        #1;
        in_valid = 1'b0;
        if (!acc) chk("accept_timeout", 68'd0, 68'd1);
    endtask

    task automatic issue_rand();
        logic [31:0] a, b;
        logic        c, s;
        a = $urandom; b = $urandom;
        c = 1'($urandom_range(0, 1));
        s = 1'($urandom_range(0, 1));
        issue(a, b, c, s, ref_add({32'd0, a}, {32'd0, b}, c, s, 32));
    endtask

    task automatic drain(input string nm);
        for (int t = 0; t < 200 && q_m.size() != 0; t++) @(negedge clk);
        chk(nm, 68'(q_m.size()), 68'd0);
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        bit          pop;
        logic [67:0] e;
        if (rst) begin
            prev_pop = 0;
        end else begin
            pop = out_valid && out_ready;
            if (pop) begin
                if (q_m.size() == 0) begin
                    chk("main_unexpected", 68'd1, 68'd0);
                end else begin
                    e = q_m.pop_front();
                    chk("main_result", {Cout, Ovf, Zero, Neg, 32'd0, Out}, e);
                end
                streak = prev_pop ? streak + 1 : 1;
                if (streak > max_streak) max_streak = streak;
            end
            prev_pop = pop;
        end
    end

    for (genvar g = 0; g < 3; g++) begin : g_sw
        localparam int W = (g == 0) ? 8 : (g == 1) ? 16 : 64;
        localparam int S = (g == 0) ? 1 : (g == 1) ? 2 : 8;

        logic         iv, ir, ov, ordy, cin, sub, co, vf, z, n;
        logic [W-1:0] a, b, o;
        logic [67:0]  q [$];

        pipelined_adder #(
            .WIDTH (W),
            .STAGES(S)
        ) dut_sw (
            .clk      (clk),
            .rst      (rst),
            .in_valid (iv),
            .in_ready (ir),
            .A        (a),
            .B        (b),
            .Cin      (cin),
            .Sub      (sub),
            .out_valid(ov),
            .out_ready(ordy),
            .Out      (o),
            .Cout     (co),
            .Ovf      (vf),
            .Zero     (z),
            .Neg      (n)
        );

        initial begin
            ordy = 1'b1;
            wait (sw_go);
            while (!sw_done[g]) begin
                @(posedge clk);
                #1;
                ordy = ($urandom_range(0, 3) != 0);
            end
            ordy = 1'b1;
        end

        initial begin
            bit acc;
            iv = 1'b0; a = '0; b = '0; cin = 1'b0; sub = 1'b0;
            wait (sw_go);
            @(posedge clk);
            #1;
            for (int i = 0; i < 1000; i++) begin
                a   = W'({$urandom, $urandom});
                b   = W'({$urandom, $urandom});
                cin = 1'($urandom_range(0, 1));
                sub = 1'($urandom_range(0, 1));
                case (i % 50)
                    0: begin a = '0; b = '0; end
                    1: begin a = '1; b = '1; end
                    2: begin sub = 1'b0; cin = 1'b1; end
                    default: ;
                endcase
                iv  = 1'b1;
                acc = 0;
                for (int t = 0; t < 100 && !acc; t++) begin
                    @(negedge clk);
                    if (ir) begin
                        @(posedge clk);
                        q.push_back(ref_add(64'(a), 64'(b), cin, sub, W));
                        acc = 1;
                    end else begin
                        @(posedge clk);
                    end
                end
                #1;
                iv = 1'b0;
                if (!acc) chk($sformatf("sw%0d_accept_timeout", W), 68'd0, 68'd1);
                if ($urandom_range(0, 4) == 0) begin
                    @(posedge clk);
                    #1;
                end
            end
            for (int t = 0; t < 500 && q.size() != 0; t++) @(negedge clk);
            chk($sformatf("sw%0d_drain", W), 68'(q.size()), 68'd0);
            sw_done[g] = 1;
        end

        always @(negedge clk) begin
            logic [67:0] e;
            if (!rst && ov && ordy) begin
                if (q.size() == 0) begin
                    chk($sformatf("sw%0d_unexpected", W), 68'd1, 68'd0);
                end else begin
                    e = q.pop_front();
                    chk($sformatf("sw%0d_result", W), {co, vf, z, n, 64'(o)}, e);
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int lat;
        int cnt;
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        A = '0; B = '0; Cin = 1'b0; Sub = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_out_valid", 68'(out_valid), 68'd0);
        chk("rst_in_ready", 68'(in_ready), 68'd1);
        chk("rst_out", 68'(Out), 68'd0);
        chk("rst_flags", 68'({Cout, Ovf, Zero, Neg}), 68'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("rel_in_ready", 68'(in_ready), 68'd1);
        @(posedge clk);
        #1;

        // Carry ripples through every slice; also measures latency.
        issue(32'hFFFF_FFFF, 32'd1, 1'b0, 1'b0, mk(1, 0, 1, 0, 64'd0));
        lat = 1;
        for (int t = 0; t < 20; t++) begin
            @(negedge clk);
            if (out_valid) break;
            @(posedge clk);
            lat++;
        end
        chk("t1_latency", 68'(lat), 68'd4);
        drain("t1_drain");

        issue(32'h8000_0000, 32'd1, 1'b1, 1'b1, mk(1, 1, 0, 0, 64'h7FFF_FFFF));
        issue(32'd1, 32'd2, 1'b1, 1'b0, mk(0, 0, 0, 0, 64'd4));
        issue(32'h7FFF_FFFF, 32'd1, 1'b0, 1'b0, mk(0, 1, 0, 1, 64'h8000_0000));
        issue(32'd5, 32'd5, 1'b1, 1'b1, mk(1, 0, 1, 0, 64'd0));
        issue(32'd0, 32'd1, 1'b1, 1'b1, mk(0, 0, 0, 1, 64'hFFFF_FFFF));
        issue(32'd0, 32'd0, 1'b0, 1'b0, mk(0, 0, 1, 0, 64'd0));
        issue(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b0, mk(1, 0, 0, 1, 64'hFFFF_FFFF));
        issue(32'h0000_FFFF, 32'd1, 1'b0, 1'b0, mk(0, 0, 0, 0, 64'h0001_0000));
        drain("t2_drain");

        max_streak = 0;
        for (int i = 0; i < 16; i++) issue_rand();
        drain("t3_drain");
        chk("t3_streak", 68'(max_streak), 68'd16);

        out_ready = 1'b0;
        issue(32'd10, 32'd3, 1'b0, 1'b0, mk(0, 0, 0, 0, 64'd13));
        issue(32'd20, 32'd7, 1'b1, 1'b1, mk(1, 0, 0, 0, 64'd13));
        issue(32'd1, 32'd1, 1'b0, 1'b0, mk(0, 0, 0, 0, 64'd2));
        issue(32'h100, 32'h100, 1'b0, 1'b0, mk(0, 0, 0, 0, 64'h200));
        A = 32'd3; B = 32'd4; Cin = 1'b0; Sub = 1'b0; in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("t4_in_ready", 68'(in_ready), 68'd0);
            chk("t4_hold", 68'({out_valid, Out}), {35'd0, 1'b1, 32'd13});
            @(posedge clk);
        end
        #1;
        out_ready = 1'b1;
        issue(32'd3, 32'd4, 1'b0, 1'b0, mk(0, 0, 0, 0, 64'd7));
        drain("t4_drain");

        fork
            for (int i = 0; i < 20; i++) issue_rand();
            for (int i = 0; i < 80; i++) begin
                @(posedge clk);
                #1;
                out_ready = ($urandom_range(0, 2) != 0);
            end
        join
        out_ready = 1'b1;
        drain("mix_drain");

        out_ready = 1'b0;
        issue(32'd1, 32'd1, 1'b0, 1'b0, mk(0, 0, 0, 0, 64'd2));
        issue(32'd2, 32'd2, 1'b0, 1'b0, mk(0, 0, 0, 0, 64'd4));
        issue(32'd3, 32'd3, 1'b0, 1'b0, mk(0, 0, 0, 0, 64'd6));
        issue(32'd4, 32'd4, 1'b0, 1'b0, mk(0, 0, 0, 0, 64'd8));
        chk("t5_full", 68'({out_valid, Out}), {35'd0, 1'b1, 32'd2});
        #2;
        rst = 1'b1;
        #1;
        chk("t5_async_valid", 68'(out_valid), 68'd0);
        chk("t5_async_data", 68'({Cout, Ovf, Zero, Neg, Out}), 68'd0);
        q_m.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
        out_ready = 1'b1;
        cnt = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (out_valid) cnt++;
        end
        chk("t5_stale", 68'(cnt), 68'd0);
        chk("t5_in_ready", 68'(in_ready), 68'd1);
        @(posedge clk);
        #1;
        issue(32'd9, 32'd9, 1'b1, 1'b1, mk(1, 0, 1, 0, 64'd0));
        drain("t5_post_drain");

        sw_go = 1;
        for (int t = 0; t < 20000 && !(sw_done[0] && sw_done[1] && sw_done[2]); t++)
            @(posedge clk);
        chk("sweep_done", 68'({sw_done[0], sw_done[1], sw_done[2]}), 68'd7);

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
